// File: rtl/shreg_var_pkg.sv
// Package for the programmable-depth SRL delay line (shreg_var_ff).
// Holds the control state encoding, the absolute depth ceiling and a helper
// that sizes the SRL32 cascade for a given maximum depth.
package shreg_var_pkg;

  typedef enum logic [1:0] {
    PURGE  = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    SWITCH = 2'd3
  } state_t;

  localparam int MAX_DEPTH_LIMIT = 64;
  localparam int SRL_SEG_LEN     = 32;

  // The output FF supplies the last stage, so the SRL only needs depth-1
  // cells; round that up to whole SRL32 segments.
  function automatic int srl_seg_count(input int depth);
    return (depth - 1 + SRL_SEG_LEN - 1) / SRL_SEG_LEN;
  endfunction

endpackage

// File: rtl/srl_var_lane.sv
// One-bit cascaded SRL32 chain with an addressable tap.
//   CLK  : clock
//   ce   : shift enable
//   addr : tap address, 0 = newest cell (q is the input delayed addr+1 shifts)
//   d    : serial input
//   q    : combinational tap output
// NSEG (1 or 2) is the number of SRL32 segments; addr[5] selects the segment.
// Cells have no reset, matching the primitive.
module srl_var_lane
  import shreg_var_pkg::*;
#(
  parameter int NSEG = 1
) (
  input  logic       CLK,
  input  logic       ce,
  input  logic [5:0] addr,
  input  logic       d,
  output logic       q
);

  localparam int LEN = NSEG * SRL_SEG_LEN;

  logic [LEN-1:0] chain;

  always_ff @(posedge CLK) begin
    if (ce) chain <= {chain[LEN-2:0], d};
  end

  if (NSEG == 1) begin : g_one
    logic addr_hi_unused;
    assign addr_hi_unused = addr[5];
    assign q = chain[addr[4:0]];
  end else begin : g_two
    assign q = chain[addr];
  end

endmodule

// File: rtl/shreg_var_ff.sv
// Enabled shift-register delay line with run-time programmable depth
// (2..MAX_DEPTH) built from cascaded SRL32 lanes plus one output register.
// Each word carries a valid tag; depth changes drain in-flight words first.
//   CLK, rst       : clock, synchronous active-high reset
//   en             : global enable for shifting, counting and the FSM
//   i, i_valid     : input word and qualifier; i_ready accepts in RUN only
//   o, o_valid     : registered delayed word and its tag (o holds last word)
//   depth_in/wr    : depth load request; depth_err is sticky on bad depth
//   depth_cur      : depth in effect; busy is high outside RUN
//   fill_cnt       : valid words inside the SRL section (o excluded)
//   o_perr         : sticky parity error, only with SHREG_VAR_PARITY_EN
// Optional build macro: SHREG_VAR_PARITY_EN adds an even-parity lane.
module shreg_var_ff
  import shreg_var_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               MAX_DEPTH = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] INIT      = '0,
  parameter int               DEPTH_W   = 7
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH-1:0]   i,
  input  logic               i_valid,
  output logic               i_ready,
  output logic [WIDTH-1:0]   o,
  output logic               o_valid,
`ifdef SHREG_VAR_PARITY_EN
  output logic               o_perr,
`endif
  input  logic [DEPTH_W-1:0] depth_in,
  input  logic               depth_wr,
  output logic               depth_err,
  output logic [DEPTH_W-1:0] depth_cur,
  output logic               busy,
  output logic [DEPTH_W-1:0] fill_cnt
);

  localparam int NSEG = srl_seg_count(MAX_DEPTH);
`ifdef SHREG_VAR_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int LANES = WIDTH + 1 + PAR_W;
  localparam logic [DEPTH_W-1:0] PURGE_LAST = DEPTH_W'(MAX_DEPTH - 1);
  localparam logic [DEPTH_W-1:0] ONE        = DEPTH_W'(1);

  function automatic logic [DEPTH_W-1:0] fill_next(input logic [DEPTH_W-1:0] cnt,
                                                   input logic inc, input logic dec);
    logic [DEPTH_W-1:0] r;
    r = cnt;
    if (inc && !dec && cnt != '1)      r = cnt + ONE;
    else if (dec && !inc && cnt != '0) r = cnt - ONE;
    return r;
  endfunction

  state_t             state, state_nxt;
  logic [DEPTH_W-1:0] purge_cnt;
  logic [DEPTH_W-1:0] pend_depth;
  // After a depth switch, cells inside the new tap range may still hold
  // words that already left through the old tap. New words need depth-1
  // shifts to reach the tap, so the tag is ignored for that long.
  logic [DEPTH_W-1:0] mask_cnt;

  logic [LANES-1:0]   lane_d, lane_q;
  logic [5:0]         tap_addr;
  logic [WIDTH-1:0]   tap_data_p0;
  logic               tap_vld_p0;
  logic               depth_ok;
  logic               acc;

  assign acc      = i_valid & i_ready;
  assign depth_ok = (depth_in >= DEPTH_W'(2)) && (depth_in <= DEPTH_W'(MAX_DEPTH));
  assign tap_addr = 6'(depth_cur - DEPTH_W'(2));

`ifdef SHREG_VAR_PARITY_EN
  assign lane_d = {^i, acc, i};
`else
  assign lane_d = {acc, i};
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    srl_var_lane #(.NSEG(NSEG)) u_lane (
      .CLK  (CLK),
      .ce   (en),
      .addr (tap_addr),
      .d    (lane_d[g]),
      .q    (lane_q[g])
    );
  end

  // ---- stage p0: SRL tap (combinational) ----
  assign tap_data_p0 = lane_q[WIDTH-1:0];
  assign tap_vld_p0  = lane_q[WIDTH] && (state != PURGE) && (mask_cnt == '0);

  always_ff @(posedge CLK) begin
    if (rst)     state <= PURGE;
    else if (en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    i_ready   = 1'b0;
    busy      = 1'b1;
    case (state)
      PURGE:  if (purge_cnt == PURGE_LAST) state_nxt = RUN;
      RUN: begin
        i_ready = 1'b1;
        busy    = 1'b0;
        if (depth_wr && depth_ok && depth_in != depth_cur) state_nxt = DRAIN;
      end
      DRAIN:  if (fill_cnt == '0 && !tap_vld_p0) state_nxt = SWITCH;
      SWITCH: state_nxt = RUN;
      default: state_nxt = PURGE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      purge_cnt  <= '0;
      depth_cur  <= DEPTH_W'(DEPTH);
      pend_depth <= DEPTH_W'(DEPTH);
      mask_cnt   <= '0;
      fill_cnt   <= '0;
      depth_err  <= 1'b0;
      o_valid    <= 1'b0;
    end else if (en) begin
      if (state == PURGE) purge_cnt <= purge_cnt + ONE;
      if (state == RUN && depth_wr) begin
        if (!depth_ok) depth_err  <= 1'b1;
        else           pend_depth <= depth_in;
      end
      if (state == SWITCH) begin
        depth_cur <= pend_depth;
        mask_cnt  <= pend_depth - ONE;
      end else if (mask_cnt != '0) begin
        mask_cnt  <= mask_cnt - ONE;
      end
      fill_cnt <= fill_next(fill_cnt, acc, tap_vld_p0);
      o_valid  <= tap_vld_p0;
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge CLK) begin
    if (rst)                    o <= INIT;
    else if (en && tap_vld_p0) o <= tap_data_p0;
  end

`ifdef SHREG_VAR_PARITY_EN
  always_ff @(posedge CLK) begin
    if (rst) o_perr <= 1'b0;
    else if (en && tap_vld_p0 && (^{lane_q[WIDTH+1], tap_data_p0})) o_perr <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_shreg_var_ff.sv
module tb_shreg_var_ff;

  localparam int          W    = 32;
  localparam int          MAXD = 32;
  localparam int          D0   = 5;
  localparam logic [31:0] INIT = 32'hA5A5_0F0F;
  localparam int M_PURGE = 0, M_RUN = 1, M_DRAIN = 2, M_SWITCH = 3;

  logic         CLK = 1'b0;
  logic         rst = 1'b0, en = 1'b0, i_valid = 1'b0, depth_wr = 1'b0;
  logic [31:0]  i = '0;
  logic [6:0]   depth_in = '0;
  logic         i_ready, o_valid, depth_err, busy;
  logic [31:0]  o;
  logic [6:0]   depth_cur, fill_cnt;
`ifdef SHREG_VAR_PARITY_EN
  logic         o_perr;
`endif

  int checks = 0, failures = 0;

  shreg_var_ff #(.WIDTH(W), .MAX_DEPTH(MAXD), .DEPTH(D0), .INIT(INIT), .DEPTH_W(7)) dut (
    .CLK(CLK), .rst(rst), .en(en), .i(i), .i_valid(i_valid), .i_ready(i_ready),
    .o(o), .o_valid(o_valid),
`ifdef SHREG_VAR_PARITY_EN
    .o_perr(o_perr),
`endif
    .depth_in(depth_in), .depth_wr(depth_wr), .depth_err(depth_err),
    .depth_cur(depth_cur), .busy(busy), .fill_cnt(fill_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference model: words are time-stamped in enabled edges. A word captured
  // on enabled edge c is due on o at enabled edge c+depth-1.
  typedef struct { logic [31:0] data; int due; } word_t;
  word_t       q_m[$];
  int          n_edge = 0, m_mode = M_PURGE, purge_done = 0;
  int          m_dcur = D0, m_pend = D0;
  bit          m_err = 0, m_ov = 0;
  logic [31:0] m_o = INIT;

  task automatic model_edge(input bit r, input bit e, input bit iv, input logic [31:0] d,
                            input bit wr, input int din);
    int pre_fill;
    bit acc, exiting;
    if (r) begin
      q_m.delete(); m_mode = M_PURGE; purge_done = 0; m_dcur = D0; m_pend = D0;
      m_err = 0; m_o = INIT; m_ov = 0;
      return;
    end
    if (!e) return;
    n_edge++;
    pre_fill = q_m.size();
    acc = (m_mode == M_RUN) && iv;
    exiting = 0;
    m_ov = 0;
    if (q_m.size() > 0 && q_m[0].due == n_edge) begin
      m_o = q_m[0].data; m_ov = 1; exiting = 1;
      void'(q_m.pop_front());
    end
    if (acc) q_m.push_back('{d, n_edge + m_dcur - 1});
    case (m_mode)
      M_PURGE: begin purge_done++; if (purge_done == MAXD) m_mode = M_RUN; end
      M_RUN: if (wr) begin
        if (din < 2 || din > MAXD) m_err = 1;
        else if (din != m_dcur) begin m_pend = din; m_mode = M_DRAIN; end
      end
      M_DRAIN: if (pre_fill == 0 && !exiting) m_mode = M_SWITCH;
      default: begin m_dcur = m_pend; m_mode = M_RUN; end
    endcase
  endtask

  task automatic cyc();
    bit          r_s  = rst, e_s = en, iv_s = i_valid, wr_s = depth_wr;
    logic [31:0] d_s  = i;
    int          din_s = int'(depth_in);
    @(posedge CLK);
    #1;
    model_edge(r_s, e_s, iv_s, d_s, wr_s, din_s);
  endtask

  task automatic test_reset();
    rst = 1; en = 1; i_valid = 0; depth_wr = 0;
    cyc(); cyc();
    rst = 0;
    checks++; if (o !== INIT)       begin failures++; $display("FAIL reset_o got=%h exp=%h", o, INIT); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
    checks++; if (i_ready !== 1'b0) begin failures++; $display("FAIL reset_i_ready got=%b exp=0", i_ready); end
    checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (depth_cur !== 7'(D0)) begin failures++; $display("FAIL reset_depth_cur got=%0d exp=%0d", depth_cur, D0); end
    checks++; if (fill_cnt !== 7'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_cnt); end
    checks++; if (depth_err !== 1'b0) begin failures++; $display("FAIL reset_depth_err got=%b exp=0", depth_err); end
  endtask

  task automatic test_purge();
    en = 1; i_valid = 0;
    for (int c = 1; c <= MAXD; c++) begin
      depth_wr = (c == 10); depth_in = 7'd0;
      cyc();
      checks++; if (busy !== (c < MAXD)) begin failures++; $display("FAIL purge_busy c=%0d got=%b exp=%b", c, busy, c < MAXD); end
      checks++; if (i_ready !== (c == MAXD)) begin failures++; $display("FAIL purge_i_ready c=%0d got=%b exp=%b", c, i_ready, c == MAXD); end
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL purge_o_valid c=%0d got=%b exp=0", c, o_valid); end
    end
    depth_wr = 0;
    checks++; if (o !== INIT) begin failures++; $display("FAIL purge_o got=%h exp=%h", o, INIT); end
    checks++; if (depth_err !== 1'b0) begin failures++; $display("FAIL purge_wr_ignored got=%b exp=0", depth_err); end
  endtask

  task automatic test_latency();
    logic [31:0] tab [3] = '{32'h11, 32'h22, 32'h33};
    int          fill_tab [9] = '{1, 2, 3, 3, 2, 1, 0, 0, 0};
    int          peak = 0;
    logic [31:0] exp_o;
    for (int e = 1; e <= 9; e++) begin
      i_valid = (e <= 3);
      i = (e <= 3) ? tab[e-1] : $urandom;
      cyc();
      exp_o = (e < 5) ? INIT : tab[((e > 7) ? 7 : e) - 5];
      if (int'(fill_cnt) > peak) peak = int'(fill_cnt);
      checks++; if (o_valid !== (e >= 5 && e <= 7)) begin failures++; $display("FAIL lat_o_valid e=%0d got=%b", e, o_valid); end
      checks++; if (o !== exp_o) begin failures++; $display("FAIL lat_o e=%0d got=%h exp=%h", e, o, exp_o); end
      checks++; if (fill_cnt !== 7'(fill_tab[e-1])) begin failures++; $display("FAIL lat_fill e=%0d got=%0d exp=%0d", e, fill_cnt, fill_tab[e-1]); end
    end
    i_valid = 0;
    checks++; if (peak != 3) begin failures++; $display("FAIL lat_fill_peak got=%0d exp=3", peak); end
  endtask

  task automatic test_en_gating();
    logic [31:0] tab [3] = '{32'h44, 32'h55, 32'h66};
    int          fill_tab [10] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 0};
    int          e = 0;
    logic [31:0] exp_o;
    for (int c = 0; e < 9; c++) begin
      en = (c % 2 == 0);
      i_valid = (e < 3);
      i = tab[(e < 3) ? e : 0];
      cyc();
      if (en) e++;
      exp_o = (e < 5) ? 32'h33 : tab[((e > 7) ? 7 : e) - 5];
      checks++; if (o_valid !== (e >= 5 && e <= 7)) begin failures++; $display("FAIL gate_o_valid c=%0d e=%0d got=%b", c, e, o_valid); end
      checks++; if (o !== exp_o) begin failures++; $display("FAIL gate_o c=%0d got=%h exp=%h", c, o, exp_o); end
      checks++; if (fill_cnt !== 7'(fill_tab[e])) begin failures++; $display("FAIL gate_fill c=%0d got=%0d exp=%0d", c, fill_cnt, fill_tab[e]); end
    end
    en = 1; i_valid = 0;
  endtask

  task automatic test_depth_change();
    logic [31:0] tab [3] = '{32'h77, 32'h88, 32'h99};
    logic [31:0] exp_o = 32'h66;
    bit          exp_busy, exp_ov;
    int          exp_fill, exp_d;
    for (int e = 1; e <= 31; e++) begin
      i_valid  = (e <= 3) || (e >= 5 && e <= 10);
      i        = (e <= 3) ? tab[e-1] : ((e == 10) ? 32'hCAFE_F00D : 32'hDEAD_0000 + e);
      depth_wr = (e == 4); depth_in = 7'd20;
      cyc();
      exp_busy = (e >= 4 && e <= 8);
      exp_d    = (e <= 8) ? 5 : 20;
      exp_ov   = (e >= 5 && e <= 7) || (e == 29);
      if (e >= 5 && e <= 7) exp_o = tab[e-5];
      if (e == 29) exp_o = 32'hCAFE_F00D;
      exp_fill = (e <= 3) ? e : (e == 4) ? 3 : (e <= 7) ? 7 - e : (e <= 9) ? 0 : (e <= 28) ? 1 : 0;
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL dchg_busy e=%0d got=%b exp=%b", e, busy, exp_busy); end
      checks++; if (i_ready !== !exp_busy) begin failures++; $display("FAIL dchg_i_ready e=%0d got=%b exp=%b", e, i_ready, !exp_busy); end
      checks++; if (depth_cur !== 7'(exp_d)) begin failures++; $display("FAIL dchg_depth e=%0d got=%0d exp=%0d", e, depth_cur, exp_d); end
      checks++; if (o_valid !== exp_ov) begin failures++; $display("FAIL dchg_o_valid e=%0d got=%b exp=%b", e, o_valid, exp_ov); end
      checks++; if (o !== exp_o) begin failures++; $display("FAIL dchg_o e=%0d got=%h exp=%h", e, o, exp_o); end
      checks++; if (fill_cnt !== 7'(exp_fill)) begin failures++; $display("FAIL dchg_fill e=%0d got=%0d exp=%0d", e, fill_cnt, exp_fill); end
    end
    i_valid = 0; depth_wr = 0;
  endtask

  task automatic test_depth_err();
    depth_wr = 1; depth_in = 7'd1; cyc(); depth_wr = 0;
    checks++; if (depth_err !== 1'b1) begin failures++; $display("FAIL err_low got=%b exp=1", depth_err); end
    checks++; if (depth_cur !== 7'd20) begin failures++; $display("FAIL err_low_depth got=%0d exp=20", depth_cur); end
    cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL err_low_busy got=%b exp=0", busy); end
    depth_wr = 1; depth_in = 7'd40; cyc(); depth_wr = 0; cyc();
    checks++; if (depth_cur !== 7'd20 || busy !== 1'b0) begin failures++; $display("FAIL err_high depth=%0d busy=%b exp 20/0", depth_cur, busy); end
    depth_wr = 1; depth_in = 7'd20; cyc(); depth_wr = 0; cyc();
    checks++; if (busy !== 1'b0 || depth_cur !== 7'd20) begin failures++; $display("FAIL same_depth busy=%b depth=%0d exp 0/20", busy, depth_cur); end
    rst = 1; cyc(); rst = 0;
    checks++; if (depth_err !== 1'b0) begin failures++; $display("FAIL err_rst got=%b exp=0", depth_err); end
    checks++; if (depth_cur !== 7'(D0)) begin failures++; $display("FAIL err_rst_depth got=%0d exp=%0d", depth_cur, D0); end
    for (int c = 0; c < MAXD; c++) cyc();
    en = 0; depth_wr = 1; depth_in = 7'd0; cyc();
    depth_in = 7'd8; cyc();
    en = 1; depth_wr = 0; cyc();
    checks++; if (depth_err !== 1'b0) begin failures++; $display("FAIL lost_wr_err got=%b exp=0", depth_err); end
    checks++; if (busy !== 1'b0 || depth_cur !== 7'(D0)) begin failures++; $display("FAIL lost_wr busy=%b depth=%0d exp 0/%0d", busy, depth_cur, D0); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      en       = ($urandom_range(0, 3) != 0);
      i_valid  = $urandom_range(0, 1);
      i        = $urandom;
      depth_wr = ($urandom_range(0, 29) == 0);
      depth_in = 7'($urandom_range(0, 40));
      rst      = ($urandom_range(0, 1999) == 0);
      cyc();
      checks++; if (o_valid !== m_ov) begin failures++; $display("FAIL rnd_o_valid c=%0d got=%b exp=%b", c, o_valid, m_ov); end
      checks++; if (o !== m_o) begin failures++; $display("FAIL rnd_o c=%0d got=%h exp=%h", c, o, m_o); end
      checks++; if (fill_cnt !== 7'(q_m.size())) begin failures++; $display("FAIL rnd_fill c=%0d got=%0d exp=%0d", c, fill_cnt, q_m.size()); end
      checks++; if (i_ready !== (m_mode == M_RUN)) begin failures++; $display("FAIL rnd_i_ready c=%0d got=%b", c, i_ready); end
      checks++; if (busy !== (m_mode != M_RUN)) begin failures++; $display("FAIL rnd_busy c=%0d got=%b", c, busy); end
      checks++; if (depth_cur !== 7'(m_dcur)) begin failures++; $display("FAIL rnd_depth c=%0d got=%0d exp=%0d", c, depth_cur, m_dcur); end
      checks++; if (depth_err !== m_err) begin failures++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, depth_err, m_err); end
    end
    rst = 0; depth_wr = 0; en = 1;
`ifdef SHREG_VAR_PARITY_EN
    checks++; if (o_perr !== 1'b0) begin failures++; $display("FAIL parity_clean got=%b exp=0", o_perr); end
`endif
  endtask

  initial begin
    test_reset();
    test_purge();
    test_latency();
    test_en_gating();
    test_depth_change();
    test_depth_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
